// File: rtl/ms_stopwatch.sv
// rtl/ms_stopwatch.sv - millisecond stopwatch with run/pause/clear, lap capture and sticky overflow
module ms_stopwatch #(
  parameter int MAX_MIN = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       lap,
  output logic [9:0] ms,
  output logic [5:0] sec,
  output logic [6:0] min,
  output logic       running,
  output logic [9:0] lap_ms,
  output logic [5:0] lap_sec,
  output logic [6:0] lap_min,
  output logic       lap_valid,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  localparam logic [6:0] MAX_MIN_W = 7'(MAX_MIN);

  state_t     state_q, state_d;
  logic       tick_q;
  logic       ms_evt;
  logic [9:0] ms_q, ms_d;
  logic [5:0] sec_q, sec_d;
  logic [6:0] min_q, min_d;
  logic       ovf_q, ovf_d;
  logic [9:0] lap_ms_q, lap_ms_d;
  logic [5:0] lap_sec_q, lap_sec_d;
  logic [6:0] lap_min_q, lap_min_d;
  logic       lap_valid_q, lap_valid_d;

  // tick is already in the clk domain, so a single delay register is enough for edge detect
  assign ms_evt = tick & ~tick_q;

  // Next state: clear beats stop, and an asserted stop also masks start in the same cycle
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (stop) begin
      if (state_q == RUN) state_d = PAUSED;
    end else if (start && state_q != RUN) begin
      state_d = RUN;
    end
  end

  // Counter carry chain, lap snapshot and clear; counting keys off the current state only
  always_comb begin
    ms_d        = ms_q;
    sec_d       = sec_q;
    min_d       = min_q;
    ovf_d       = ovf_q;
    lap_ms_d    = lap_ms_q;
    lap_sec_d   = lap_sec_q;
    lap_min_d   = lap_min_q;
    lap_valid_d = 1'b0;
    if (clear) begin
      ms_d      = '0;
      sec_d     = '0;
      min_d     = '0;
      ovf_d     = 1'b0;
      lap_ms_d  = '0;
      lap_sec_d = '0;
      lap_min_d = '0;
    end else begin
      if (lap && state_q != IDLE) begin
        lap_ms_d    = ms_q;
        lap_sec_d   = sec_q;
        lap_min_d   = min_q;
        lap_valid_d = 1'b1;
      end
      if (state_q == RUN && ms_evt) begin
        if (ms_q == 10'd999) begin
          ms_d = '0;
          if (sec_q == 6'd59) begin
            sec_d = '0;
            if (min_q == MAX_MIN_W) begin
              min_d = '0;
              ovf_d = 1'b1;
            end else begin
              min_d = min_q + 7'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end else begin
          ms_d = ms_q + 10'd1;
        end
      end
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      tick_q      <= 1'b0;
      ms_q        <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      ovf_q       <= 1'b0;
      lap_ms_q    <= '0;
      lap_sec_q   <= '0;
      lap_min_q   <= '0;
      lap_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick;
      ms_q        <= ms_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      ovf_q       <= ovf_d;
      lap_ms_q    <= lap_ms_d;
      lap_sec_q   <= lap_sec_d;
      lap_min_q   <= lap_min_d;
      lap_valid_q <= lap_valid_d;
    end
  end

  assign ms        = ms_q;
  assign sec       = sec_q;
  assign min       = min_q;
  assign running   = (state_q == RUN);
  assign lap_ms    = lap_ms_q;
  assign lap_sec   = lap_sec_q;
  assign lap_min   = lap_min_q;
  assign lap_valid = lap_valid_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ms_stopwatch.sv
// tb/tb_ms_stopwatch.sv - randomized and directed self-checking bench for ms_stopwatch
module tb_ms_stopwatch;

  localparam int MAXM = 5;
  localparam int WRAP = (MAXM + 1) * 60000;

  logic       clk;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic [9:0] ms;
  logic [5:0] sec;
  logic [6:0] min;
  logic       running;
  logic [9:0] lap_ms;
  logic [5:0] lap_sec;
  logic [6:0] lap_min;
  logic       lap_valid;
  logic       overflow;

  ms_stopwatch #(.MAX_MIN(MAXM)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .ms(ms), .sec(sec), .min(min), .running(running),
    .lap_ms(lap_ms), .lap_sec(lap_sec), .lap_min(lap_min),
    .lap_valid(lap_valid), .overflow(overflow)
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  bit preset_req = 1'b0;
  int preset_val = 0;

  // model: elapsed time as one integer of ms; mode 0 idle, 1 run, 2 paused
  int m_t = 0;
  int m_mode = 0;
  bit m_ovf = 1'b0;
  int m_lap = 0;
  bit m_lv = 1'b0;
  bit m_prev = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model advanced on each clock, reset asynchronously like the DUT
  always @(posedge clk or negedge rst) begin
    int nt, nm, nl;
    bit nov, nv;
    if (!rst) begin
      m_t <= 0; m_mode <= 0; m_ovf <= 1'b0; m_lap <= 0; m_lv <= 1'b0; m_prev <= 1'b0;
    end else begin
      nt = m_t; nm = m_mode; nov = m_ovf; nl = m_lap; nv = 1'b0;
      if (clear) begin
        nt = 0; nm = 0; nov = 1'b0; nl = 0;
      end else begin
        if (lap && m_mode != 0) begin
          nl = m_t;
          nv = 1'b1;
        end
        if (m_mode == 1 && tick && !m_prev) begin
          nt = m_t + 1;
          if (nt == WRAP) begin
            nt = 0;
            nov = 1'b1;
          end
        end
        if (stop) begin
          if (m_mode == 1) nm = 2;
        end else if (start && m_mode != 1) begin
          nm = 1;
        end
      end
      if (preset_req) nt = preset_val;
      m_t <= nt; m_mode <= nm; m_ovf <= nov; m_lap <= nl; m_lv <= nv; m_prev <= tick;
    end
  end

  // Compare every output against the model away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ms", int'(ms), m_t % 1000);
      chk("sec", int'(sec), (m_t / 1000) % 60);
      chk("min", int'(min), m_t / 60000);
      chk("running", int'(running), (m_mode == 1) ? 1 : 0);
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("lap_ms", int'(lap_ms), m_lap % 1000);
      chk("lap_sec", int'(lap_sec), (m_lap / 1000) % 60);
      chk("lap_min", int'(lap_min), m_lap / 60000);
      chk("lap_valid", int'(lap_valid), int'(m_lv));
    end
  end

  task automatic cyc(input bit s, input bit p, input bit c, input bit l, input bit tk);
    start = s; stop = p; clear = c; lap = l; tick = tk;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, 0, 0, 1'b0);
      cyc(0, 0, 0, 0, 1'b1);
    end
  endtask

  // Loads a time into the counters while not running, keeping tick steady over the load edge
  task automatic preset(input int v);
    chk_en = 1'b0;
    force dut.ms_q = 10'(v % 1000);
    force dut.sec_q = 6'((v / 1000) % 60);
    force dut.min_q = 7'(v / 60000);
    preset_val = v;
    preset_req = 1'b1;
    cyc(0, 0, 0, 0, tick);
    release dut.ms_q;
    release dut.sec_q;
    release dut.min_q;
    preset_req = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    bit tk_n;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    cyc(0, 0, 0, 0, 0);
    chk("reset_ms", int'(ms), 0);
    chk("reset_running", int'(running), 0);
    chk("reset_overflow", int'(overflow), 0);
    chk("reset_lap_valid", int'(lap_valid), 0);
    rst = 1'b1;

    cyc(1, 0, 0, 0, 0);
    chk("start_running", int'(running), 1);
    ticks(2500);
    chk("t2500_ms", int'(ms), 500);
    chk("t2500_sec", int'(sec), 2);
    chk("t2500_min", int'(min), 0);
    chk("t2500_running", int'(running), 1);

    cyc(0, 1, 0, 0, 1);
    preset(59999);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("carry_min", int'(min), 1);
    chk("carry_sec", int'(sec), 0);
    chk("carry_ms", int'(ms), 0);

    cyc(0, 1, 0, 0, 1);
    preset(MAXM * 60000 + 59999);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("wrap_min", int'(min), 0);
    chk("wrap_ms", int'(ms), 0);
    chk("wrap_overflow", int'(overflow), 1);
    ticks(3);
    chk("ovf_hold", int'(overflow), 1);
    chk("ovf_hold_ms", int'(ms), 3);
    cyc(0, 0, 1, 0, 1);
    chk("ovf_clear", int'(overflow), 0);

    cyc(1, 0, 0, 0, 1);
    ticks(10);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1);
    chk("stop_edge_ms", int'(ms), 11);
    chk("stop_edge_running", int'(running), 0);
    ticks(3);
    chk("paused_ms", int'(ms), 11);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    chk("start_edge_ms", int'(ms), 11);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("resume_ms", int'(ms), 12);

    ticks(111);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1);
    chk("lap_ms_val", int'(lap_ms), 123);
    chk("lap_cur_ms", int'(ms), 124);
    chk("lap_pulse", int'(lap_valid), 1);
    cyc(0, 0, 0, 0, 0);
    chk("lap_pulse_end", int'(lap_valid), 0);

    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("idle_lap_pulse", int'(lap_valid), 0);
    chk("idle_lap_ms", int'(lap_ms), 0);

    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    preset(5000);
    cyc(1, 0, 0, 0, 0);
    chk("g_sec", int'(sec), 5);
    cyc(0, 1, 1, 1, 1);
    chk("g_running", int'(running), 0);
    chk("g_sec0", int'(sec), 0);
    chk("g_lap_valid", int'(lap_valid), 0);

    rst = 1'b0;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    rst = 1'b1;
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("hold_high_ms", int'(ms), 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("hold_high_next", int'(ms), 1);

    ticks(5);
    rst = 1'b0;
    #1;
    chk("async_ms", int'(ms), 0);
    chk("async_running", int'(running), 0);
    cyc(0, 0, 0, 0, 0);
    rst = 1'b1;

    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    preset(WRAP - 300);
    for (int i = 0; i < 20000; i++) begin
      tk_n = (i < 2000) ? ~tick : (($urandom_range(1, 0) == 1) ? ~tick : tick);
      rst = ($urandom_range(2999, 0) == 0) ? 1'b0 : 1'b1;
      cyc($urandom_range(15, 0) == 0, $urandom_range(31, 0) == 0,
          $urandom_range(511, 0) == 0, $urandom_range(7, 0) == 0, tk_n);
    end
    rst = 1'b1;
    cyc(0, 0, 0, 0, tick);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
